// File: rtl/mul_issue_if.sv
// Operand request and result handshakes between the EX stage, the multiply issue block and MEM writeback.
// Both directions use valid/ready: a transfer happens on a clock edge where valid and ready are both high.
interface mul_issue_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_src1;
    logic [31:0]      in_src2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Issue/collect wrapper around the 1-cycle multiplier: tracks the op in flight, picks the product half
// and buffers results in an in-order queue with a same-cycle bypass when the queue is empty.
module mul_issue_ctrl #(
    parameter int TAG_W = 5,
    parameter int DEPTH = 2
) (
    input  logic        mul_clk,
    input  logic        resetn,
    input  logic        flush,
    mul_issue_if.slave  bus,
    output logic        mul_signed,
    output logic [31:0] mul_x,
    output logic [31:0] mul_y,
    input  logic [63:0] mul_result
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } entry_t;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_hi_q, s1_hi_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];

    logic [31:0]      sel_result;
    logic [CNT_W:0]   occupancy;
    logic             in_ready;
    logic             out_valid;
    logic             q_empty;
    logic             accept;
    logic             enq;
    logic             deq;
    entry_t           head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // The multiplier has no enable, so operands are simply forwarded every cycle.
    always_comb begin
        mul_x      = bus.in_src1;
        mul_y      = bus.in_src2;
        mul_signed = (bus.in_op != 2'd2);
    end

    // Readiness counts the op still in the multiplier so every in-flight result has a queue slot.
    always_comb begin
        sel_result = s1_hi_q ? mul_result[63:32] : mul_result[31:0];
        occupancy  = (CNT_W+1)'(count_q) + (CNT_W+1)'(s1_valid_q);
        q_empty    = (count_q == '0);
        in_ready   = resetn & ~flush & (occupancy < (CNT_W+1)'(DEPTH));
        out_valid  = resetn & ~flush & (~q_empty | s1_valid_q);
        head       = mem_q[rd_ptr_q];
        accept     = bus.in_valid & in_ready;
        deq        = ~q_empty & out_valid & bus.out_ready;
        enq        = s1_valid_q & ~flush & ~(q_empty & out_valid & bus.out_ready);
    end

    always_comb begin
        bus.in_ready  = in_ready;
        bus.out_valid = out_valid;
        if (!resetn) begin
            bus.out_result = '0;
            bus.out_tag    = '0;
        end else if (!q_empty) begin
            bus.out_result = head.data;
            bus.out_tag    = head.tag;
        end else begin
            bus.out_result = sel_result;
            bus.out_tag    = s1_tag_q;
        end
    end

    always_comb begin
        s1_valid_d = accept;
        s1_hi_d    = accept ? (bus.in_op == 2'd1 || bus.in_op == 2'd2) : s1_hi_q;
        s1_tag_d   = accept ? bus.in_tag : s1_tag_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        mem_d      = mem_q;
        if (enq) begin
            mem_d[wr_ptr_q] = '{tag: s1_tag_q, data: sel_result};
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (deq) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge mul_clk) begin
        if (!resetn) begin
            s1_valid_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Payload registers carry no reset; their contents are only observed behind valid state.
    always_ff @(posedge mul_clk) begin
        s1_hi_q  <= s1_hi_d;
        s1_tag_q <= s1_tag_d;
        mem_q    <= mem_d;
    end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl with a behavioural 1-cycle multiplier and an in-order result scoreboard.
module tb_mul_issue_ctrl;
    localparam int TAG_W = 5;
    localparam int DEPTH = 2;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        mul_signed;
    logic [31:0] mul_x;
    logic [31:0] mul_y;
    logic [63:0] mul_result;

    mul_issue_if #(.TAG_W(TAG_W)) bus ();

    mul_issue_ctrl #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .mul_clk    (clk),
        .resetn     (resetn),
        .flush      (flush),
        .bus        (bus.slave),
        .mul_signed (mul_signed),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_result (mul_result)
    );

    int chk_cnt  = 0;
    int fail_cnt = 0;
    logic [TAG_W+31:0] exp_q [$];

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- multiplier model ----------------
    function automatic logic [63:0] prod64(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    always @(posedge clk) begin
        mul_result <= !resetn ? 64'd0 : prod64(mul_signed, mul_x, mul_y);
    end

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = prod64(op != 2'd2, a, b);
        return (op == 2'd1 || op == 2'd2) ? p[63:32] : p[31:0];
    endfunction

    // ---------------- checker ----------------
    task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, obs, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("out_unexpected_qsize", 64'(exp_q.size()), 64'd1);
            end else begin
                logic [TAG_W+31:0] e;
                e = exp_q.pop_front();
                check_eq("sb_result", {32'b0, bus.out_result}, {32'b0, e[31:0]});
                check_eq("sb_tag", 64'(bus.out_tag), 64'(e[TAG_W+31:32]));
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back({bus.in_tag, ref_result(bus.in_op, bus.in_src1, bus.in_src2)});
        end
        if (!resetn || flush) begin
            exp_q.delete();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [TAG_W-1:0] t);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_src1  = a;
        bus.in_src2  = b;
        bus.in_tag   = t;
    endtask

    // Issue one op and require its result on the bypass path one cycle later.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] t, input logic [31:0] exp_r, input logic chk_idle);
        drive_op(op, a, b, t);
        @(negedge clk);
        check_eq("issue_ready", 64'(bus.in_ready), 64'd1);
        if (chk_idle) check_eq("issue_idle_valid", 64'(bus.out_valid), 64'd0);
        next_cycle();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq("lat_valid", 64'(bus.out_valid), 64'd1);
        check_eq("lat_result", {32'b0, bus.out_result}, {32'b0, exp_r});
        check_eq("lat_tag", 64'(bus.out_tag), 64'(t));
        next_cycle();
    endtask

    task automatic drain(input string name);
        int k;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 12) begin
            @(posedge clk);
            k++;
        end
        #1;
        check_eq(name, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc;
        logic [TAG_W-1:0] t;
        resetn        = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'd0;
        bus.in_src1   = '0;
        bus.in_src2   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check_eq("rst_out_result", {32'b0, bus.out_result}, 64'd0);
        check_eq("rst_out_tag", 64'(bus.out_tag), 64'd0);
        next_cycle();
        resetn = 1'b1;

        // directed arithmetic cases on the bypass path
        do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0001, 1'b1);
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, 1'b1);
        do_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 1'b1);
        do_op(2'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 1'b0);
        do_op(2'd2, 32'h8000_0000, 32'h0000_0002, 5'd5, 32'h0000_0001, 1'b0);
        do_op(2'd0, 32'h0001_2345, 32'h0001_0000, 5'd6, 32'h2345_0000, 1'b0);
        do_op(2'd3, 32'hFFFF_FFFE, 32'h0000_0003, 5'd9, 32'hFFFF_FFFA, 1'b0);

        // back-to-back issue, one op per cycle
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive_op(2'd0, 32'(i + 1), 32'd3, TAG_W'(i + 1));
            else bus.in_valid = 1'b0;
            @(negedge clk);
            if (i < 4) check_eq("b2b_ready", 64'(bus.in_ready), 64'd1);
            if (i > 0) begin
                check_eq("b2b_valid", 64'(bus.out_valid), 64'd1);
                check_eq("b2b_tag", 64'(bus.out_tag), 64'(i));
            end
            next_cycle();
        end

        // backpressure: continuous issue into a stalled consumer
        bus.out_ready = 1'b0;
        acc = 0;
        t = 5'd10;
        for (int i = 0; i < 5; i++) begin
            drive_op(2'd1, $urandom, $urandom, t);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                acc++;
                t = t + 5'd1;
            end
            next_cycle();
        end
        bus.in_valid = 1'b0;
        check_eq("bp_accepted", 64'(acc), 64'd2);
        @(negedge clk);
        check_eq("bp_full_ready", 64'(bus.in_ready), 64'd0);
        check_eq("bp_hold_valid", 64'(bus.out_valid), 64'd1);
        next_cycle();
        drain("bp_drained");
        @(negedge clk);
        check_eq("bp_ready_back", 64'(bus.in_ready), 64'd1);
        check_eq("bp_no_dup", 64'(bus.out_valid), 64'd0);
        next_cycle();

        // flush with one result queued and one op in the multiplier
        bus.out_ready = 1'b0;
        drive_op(2'd0, 32'd7, 32'd6, 5'd20);
        next_cycle();
        drive_op(2'd0, 32'd2, 32'd2, 5'd21);
        next_cycle();
        drive_op(2'd0, 32'd9, 32'd9, 5'd22);
        flush = 1'b1;
        @(negedge clk);
        check_eq("fl_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("fl_in_ready", 64'(bus.in_ready), 64'd0);
        next_cycle();
        flush = 1'b0;
        bus.out_ready = 1'b1;
        do_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd23, 32'hFFFF_FFFE, 1'b1);

        // reset with two results queued
        bus.out_ready = 1'b0;
        drive_op(2'd0, 32'd11, 32'd11, 5'd24);
        next_cycle();
        drive_op(2'd0, 32'd12, 32'd12, 5'd25);
        next_cycle();
        bus.in_valid = 1'b0;
        next_cycle();
        resetn = 1'b0;
        @(negedge clk);
        check_eq("mrst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("mrst_in_ready", 64'(bus.in_ready), 64'd0);
        check_eq("mrst_out_result", {32'b0, bus.out_result}, 64'd0);
        check_eq("mrst_out_tag", 64'(bus.out_tag), 64'd0);
        next_cycle();
        resetn = 1'b1;
        bus.out_ready = 1'b1;
        do_op(2'd0, 32'd3, 32'd5, 5'd7, 32'h0000_000F, 1'b1);

        // random traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                drive_op(2'($urandom_range(0, 3)), $urandom, $urandom, TAG_W'($urandom_range(0, 31)));
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 40) == 0);
            next_cycle();
        end
        flush = 1'b0;
        drain("rand_drained");

        $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
        $finish;
    end
endmodule
